// File: rtl/button_multi_debounce.sv
// Multi-channel push-button conditioner: synchronize, debounce, then emit a
// press pulse or toggle per channel plus a long-press flag.
module button_multi_debounce #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] pressed,
    input  logic [NUM_BUTTONS-1:0] mode,
    output logic [NUM_BUTTONS-1:0] out,
    output logic [NUM_BUTTONS-1:0] held
);

    localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0]      HOLD_MAX  = 24'(HOLD_CYCLES);
    localparam logic [23:0]      HOLD_LAST = 24'(HOLD_CYCLES - 1);

    logic [NUM_BUTTONS-1:0] sync1_q, sync1_d;
    logic [NUM_BUTTONS-1:0] sync2_q, sync2_d;
    logic [NUM_BUTTONS-1:0] stable_q, stable_d;
    logic [NUM_BUTTONS-1:0] mode_q, mode_d;
    logic [NUM_BUTTONS-1:0] out_q, out_d;
    logic [NUM_BUTTONS-1:0] held_q, held_d;
    logic [CNT_W-1:0]       deb_cnt_q  [NUM_BUTTONS];
    logic [CNT_W-1:0]       deb_cnt_d  [NUM_BUTTONS];
    logic [23:0]            hold_cnt_q [NUM_BUTTONS];
    logic [23:0]            hold_cnt_d [NUM_BUTTONS];

    logic [NUM_BUTTONS-1:0] press_evt;
    logic [NUM_BUTTONS-1:0] release_evt;
    logic [NUM_BUTTONS-1:0] mode_chg;

    assign mode_chg = mode ^ mode_q;

    always_comb begin
        sync1_d     = pressed;
        sync2_d     = sync1_q;
        mode_d      = mode;
        stable_d    = stable_q;
        out_d       = out_q;
        held_d      = held_q;
        press_evt   = '0;
        release_evt = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            deb_cnt_d[i]  = deb_cnt_q[i];
            hold_cnt_d[i] = hold_cnt_q[i];

            // Counter holds the number of consecutive samples disagreeing with stable
            if (sync2_q[i] == stable_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                stable_d[i]    = ~stable_q[i];
                deb_cnt_d[i]   = '0;
                press_evt[i]   = ~stable_q[i];
                release_evt[i] = stable_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
            end

            if (press_evt[i]) begin
                hold_cnt_d[i] = '0;
            end else if (stable_q[i] && (hold_cnt_q[i] != HOLD_MAX)) begin
                hold_cnt_d[i] = hold_cnt_q[i] + 24'd1;
            end

            // Release wins if it coincides with the counter reaching its limit
            if (release_evt[i]) begin
                held_d[i] = 1'b0;
            end else if (stable_q[i] && (hold_cnt_q[i] == HOLD_LAST)) begin
                held_d[i] = 1'b1;
            end

            if (mode_chg[i]) begin
                out_d[i] = 1'b0;
            end else if (mode_q[i]) begin
                out_d[i] = out_q[i] ^ press_evt[i];
            end else begin
                out_d[i] = press_evt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            mode_q   <= '0;
            out_q    <= '0;
            held_q   <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                deb_cnt_q[i]  <= '0;
                hold_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            mode_q   <= mode_d;
            out_q    <= out_d;
            held_q   <= held_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                deb_cnt_q[i]  <= deb_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end

    assign out  = out_q;
    assign held = held_q;

endmodule

// File: tb/tb_button_multi_debounce.sv
// Scoreboard bench: a behavioural model predicts out/held after every edge and
// a separate monitor compares them against the DUT on the falling edge.
module tb_button_multi_debounce;

    localparam int NB   = 4;
    localparam int DEB  = 4;
    localparam int HOLD = 10;

    logic          clk;
    logic          reset_n;
    logic [NB-1:0] pressed;
    logic [NB-1:0] mode;
    logic [NB-1:0] out_w;
    logic [NB-1:0] held_w;

    int checks = 0;
    int errors = 0;

    logic [2*NB-1:0] exp_q[$];

    // reference model state
    int cyc = 0;
    int s1[NB];
    int s2[NB];
    int stable[NB];
    int run[NB];
    int outv[NB];
    int mprev[NB];
    int pedge[NB];
    logic [NB-1:0] exp_out;
    logic [NB-1:0] exp_held;

    button_multi_debounce #(
        .NUM_BUTTONS    (NB),
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .pressed(pressed),
        .mode   (mode),
        .out    (out_w),
        .held   (held_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge();
        int use_v;
        int press;
        int chg;
        cyc++;
        for (int i = 0; i < NB; i++) begin
            if (!reset_n) begin
                s1[i] = 0; s2[i] = 0; stable[i] = 0; run[i] = 0;
                outv[i] = 0; mprev[i] = 0; pedge[i] = 0;
                exp_out[i] = 1'b0;
                exp_held[i] = 1'b0;
            end else begin
                use_v = s2[i];
                s2[i] = s1[i];
                s1[i] = int'(pressed[i]);
                press = 0;
                if (use_v != stable[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        stable[i] = 1 - stable[i];
                        run[i] = 0;
                        press = stable[i];
                    end
                end else begin
                    run[i] = 0;
                end
                chg = (int'(mode[i]) != mprev[i]) ? 1 : 0;
                mprev[i] = int'(mode[i]);
                if (chg != 0) outv[i] = 0;
                else if (mode[i]) outv[i] = outv[i] ^ press;
                else outv[i] = press;
                if (press != 0) pedge[i] = cyc;
                exp_out[i]  = (outv[i] != 0);
                exp_held[i] = (stable[i] != 0) && ((cyc - pedge[i]) >= HOLD);
            end
        end
    endtask

    task automatic step(input logic [NB-1:0] p, input logic [NB-1:0] m, input logic rn);
        pressed = p;
        mode    = m;
        reset_n = rn;
        @(posedge clk);
        model_edge();
        exp_q.push_back({exp_out, exp_held});
        @(negedge clk);
        #1;
    endtask

    task automatic hold_for(input int n, input logic [NB-1:0] p, input logic [NB-1:0] m);
        for (int k = 0; k < n; k++) step(p, m, 1'b1);
    endtask

    // monitor
    initial begin
        logic [2*NB-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out_w !== e[2*NB-1:NB]) begin
                    errors++;
                    $display("FAIL out t=%0t got=%b want=%b", $time, out_w, e[2*NB-1:NB]);
                end
                checks++;
                if (held_w !== e[NB-1:0]) begin
                    errors++;
                    $display("FAIL held t=%0t got=%b want=%b", $time, held_w, e[NB-1:0]);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [NB-1:0] p;
        logic [NB-1:0] m;
        int flip_rng;
        reset_n = 1'b0;
        pressed = '0;
        mode    = '0;
        repeat (2) @(negedge clk);
        #1;

        // reset state
        for (int k = 0; k < 3; k++) step('0, '0, 1'b0);
        hold_for(3, '0, '0);

        // clean press, pulse mode
        hold_for(10, 4'b0001, '0);
        hold_for(8, '0, '0);

        // bounce on channel 1: 3 high / 1 low, five times
        for (int r = 0; r < 5; r++) begin
            hold_for(3, 4'b0010, '0);
            hold_for(1, '0, '0);
        end
        hold_for(6, '0, '0);

        // toggle mode on channel 2, three presses
        hold_for(2, '0, 4'b0100);
        for (int r = 0; r < 3; r++) begin
            hold_for(8, 4'b0100, 4'b0100);
            hold_for(8, '0, 4'b0100);
        end

        // long press on channel 3
        hold_for(27, 4'b1000, 4'b0100);
        hold_for(8, '0, 4'b0100);

        // reset mid-debounce, button kept high
        hold_for(2, '0, '0);
        hold_for(2, 4'b0001, '0);
        step(4'b0001, '0, 1'b0);
        step(4'b0001, '0, 1'b0);
        hold_for(12, 4'b0001, '0);
        hold_for(8, '0, '0);

        // reset mid-hold
        hold_for(12, 4'b1000, '0);
        step(4'b1000, '0, 1'b0);
        hold_for(20, 4'b1000, '0);
        hold_for(8, '0, '0);

        // simultaneous press, channels 1 and 3 toggle
        hold_for(2, '0, 4'b1010);
        hold_for(8, 4'b1111, 4'b1010);
        hold_for(8, '0, 4'b1010);

        // mode change landing on a press-event edge
        hold_for(2, '0, '0);
        hold_for(5, 4'b0001, '0);
        step(4'b0001, 4'b0001, 1'b1);
        hold_for(6, 4'b0001, 4'b0001);
        hold_for(8, '0, 4'b0001);

        // randomized traffic
        p = '0;
        m = 4'b0001;
        for (int k = 0; k < 3000; k++) begin
            flip_rng = (k < 1500) ? 9 : 29;
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, flip_rng) == 0) p[b] = ~p[b];
                if ($urandom_range(0, 149) == 0) m[b] = ~m[b];
            end
            step(p, m, ($urandom_range(0, 299) != 0));
        end
        hold_for(4, '0, m);

        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
